// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction fetch stage of the 5-stage DLX pipeline
// (producer side of the IF/ID interface).
//
// Holds the PC and fetches one word at a time over a req/valid handshake.
// After every lw it inserts a one-cycle NOP bubble, which gives decode its
// load-use gap. It honours downstream stall and branch/jump redirect, and
// discards a fetch that is still in flight when a redirect arrives.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   imem_req/addr    fetch strobe (one cycle per request) and address
//   imem_rdata/valid returned word and its valid strobe
//   stall            downstream hold: instr_if/pc_if/instr_valid/lw_bubble freeze
//   redirect(_pc)    taken branch/jump pulse and its target
//   instr_if/pc_if   instruction and its PC, to decode
//   instr_valid      instr_if is a real fetched instruction
//   lw_bubble        high while the post-lw NOP is presented
//
// Optional build macro IF_PERF_CNT_EN adds perf_fetch_cnt (issues) and
// perf_bubble_cnt (lw bubbles + redirect flushes), both 16-bit saturating.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000,
  parameter logic [5:0]  LW_OPCODE = 6'b100011
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_if,
  output logic [31:0] pc_if,
  output logic        instr_valid,
`ifdef IF_PERF_CNT_EN
  output logic [15:0] perf_fetch_cnt,
  output logic [15:0] perf_bubble_cnt,
`endif
  output logic        lw_bubble
);

  typedef enum logic [2:0] {
    S_REQ    = 3'd0,
    S_WAIT   = 3'd1,
    S_HOLD   = 3'd2,
    S_BUBBLE = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] fb, fb_n;
  logic [31:0] instr_n, pc_if_n;
  logic        valid_n, bub_n;
  logic        issue;
  logic [31:0] issue_word;
  logic        bubble_evt;

  // Request is decoded from state; gated by reset so nothing is requested
  // while the stage is held in reset.
  assign imem_req  = rst_n && (state == S_REQ);
  assign imem_addr = pc;

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    fb_n       = fb;
    instr_n    = instr_if;
    pc_if_n    = pc_if;
    valid_n    = instr_valid;
    bub_n      = lw_bubble;
    issue      = 1'b0;
    issue_word = fb;
    bubble_evt = 1'b0;

    if (redirect) begin
      // Flush wins over stall and over any issue this cycle.
      pc_n    = redirect_pc & ~32'h3;
      instr_n = NOP_WORD;
      valid_n = 1'b0;
      bub_n   = 1'b0;
      case (state)
        // Outstanding fetch not yet returned: swallow it in DRAIN.
        // If the data lands this very cycle it is dropped and the fetch
        // is complete, so there is nothing left to drain.
        S_WAIT,
        S_DRAIN: state_n = imem_valid ? S_REQ : S_DRAIN;
        default: state_n = S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: state_n = S_WAIT;
        S_WAIT: begin
          if (imem_valid) begin
            fb_n = imem_rdata;
            if (!stall) begin
              issue      = 1'b1;
              issue_word = imem_rdata;
              state_n    = (imem_rdata[31:26] == LW_OPCODE) ? S_BUBBLE : S_REQ;
            end else begin
              state_n = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            issue      = 1'b1;
            issue_word = fb;
            state_n    = (fb[31:26] == LW_OPCODE) ? S_BUBBLE : S_REQ;
          end
        end
        S_BUBBLE: begin
          if (!stall) begin
            bubble_evt = 1'b1;
            state_n    = S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem_valid) state_n = S_REQ;
        end
        default: state_n = S_REQ;
      endcase

      // Presentation registers only move when decode is not stalled.
      if (!stall) begin
        if (issue) begin
          instr_n = issue_word;
          pc_if_n = pc;
          valid_n = 1'b1;
          bub_n   = 1'b0;
          pc_n    = pc + 32'd4;  // wraps modulo 2^32
        end else if (bubble_evt) begin
          instr_n = NOP_WORD;
          valid_n = 1'b0;
          bub_n   = 1'b1;
        end else begin
          instr_n = NOP_WORD;
          valid_n = 1'b0;
          bub_n   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      fb          <= 32'h0;
      instr_if    <= NOP_WORD;
      pc_if       <= RESET_PC;
      instr_valid <= 1'b0;
      lw_bubble   <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      fb          <= fb_n;
      instr_if    <= instr_n;
      pc_if       <= pc_if_n;
      instr_valid <= valid_n;
      lw_bubble   <= bub_n;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt  <= 16'h0;
      perf_bubble_cnt <= 16'h0;
    end else begin
      if (issue && !redirect && perf_fetch_cnt != 16'hFFFF)
        perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
      if ((bubble_evt || redirect) && perf_bubble_cnt != 16'hFFFF)
        perf_bubble_cnt <= perf_bubble_cnt + 16'd1;
    end
  end
`endif

endmodule
